ltc2333_emulator: RTL and testbench

LTC2333_EMULATOR -- requirements
Module: ltc2333_emulator

---
 rtl/ltc2333_emulator.sv | 218 +++++++++++++++++++++
 tb/tb_ltc2333_emulator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2333_emulator.sv
`timescale 1ns/1ps
// ltc2333_emulator: a bank of LTC2333-style ADCs sharing cnv/scki/sdi.
// Frame bits are generated on the fly from the latched mode, count and sequence.
module ltc2333_emulator #(
   parameter int N_DEV       = 8,
   parameter int N_CH        = 8,
   parameter int RES_BITS    = 18,
   parameter int CONV_CYCLES = 50
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic             cnv,
   input  logic             scki,
   input  logic             sdi,
   output logic             busy,
   output logic [N_DEV-1:0] scko,
   output logic [N_DEV-1:0] sdo,
   output logic [15:0]      conv_count
);

   localparam int EW = RES_BITS + 6;
   localparam int BW = $clog2(EW);
   localparam int LW = $clog2(N_CH + 1);
   localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CONV = 2'd1;
   localparam logic [1:0] S_READ = 2'd2;

   logic             r_cnv_s;
   logic             r_cnv_p;
   logic             r_scki_s;
   logic             r_scki_p;
   logic             r_sdi_s;
   logic [N_DEV-1:0] r_scko;

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_mode_l;
   logic [15:0]      r_conv_count;
   logic [LW-1:0]    r_ent;
   logic [BW-1:0]    r_bit;

   logic [2:0]       r_act_chan [N_CH];
   logic [2:0]       r_act_span [N_CH];
   logic [LW-1:0]    r_act_len;
   logic [2:0]       r_pend_chan [N_CH];
   logic [2:0]       r_pend_span [N_CH];
   logic [LW-1:0]    r_pend_len;
   logic [6:0]       r_sdi_sr;
   logic [2:0]       r_sdi_cnt;

   logic             w_cnv_rise;
   logic             w_scki_rise;
   logic             w_cnv_take;
   logic             w_scki_take;
   logic             w_append;
   logic             w_in_frame;
   logic [2:0]       w_sel_chan;
   logic [2:0]       w_sel_span;
   logic [EW-1:0]    w_word [N_DEV];

   function automatic logic [RES_BITS-1:0] f_result(
      input logic [1:0]  md,
      input logic [15:0] cc,
      input logic [31:0] dev,
      input logic [2:0]  ch
   );
      logic [31:0]         t;
      logic [RES_BITS-1:0] v;
      t = '0;
      v = '0;
      case (md)
         2'd0: begin
            t = dev * 32'd16 + {29'd0, ch};
            v = RES_BITS'(t);
         end
         2'd1: begin
            t = {16'd0, cc} + {29'd0, ch};
            v = RES_BITS'(t);
         end
         2'd2: v = '0;
         default: begin
            // MSB is 1 on even counts, then alternates downward
            for (int k = 0; k < RES_BITS; k++)
               v[k] = (((RES_BITS - 1 - k) % 2) == 0) ^ cc[0];
         end
      endcase
      return v;
   endfunction

   assign w_cnv_rise  = r_cnv_s & ~r_cnv_p;
   assign w_scki_rise = r_scki_s & ~r_scki_p;
   assign w_cnv_take  = w_cnv_rise & (r_state != S_CONV);
   assign w_scki_take = w_scki_rise & (r_state == S_READ) & ~w_cnv_rise;
   assign w_append    = w_scki_take & (r_sdi_cnt == 3'd7) & r_sdi_sr[6]
                      & (r_pend_len < LW'(N_CH));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnv_s  <= 1'b0;
         r_cnv_p  <= 1'b0;
         r_scki_s <= 1'b0;
         r_scki_p <= 1'b0;
         r_sdi_s  <= 1'b0;
         r_scko   <= '0;
      end else begin
         r_cnv_s  <= cnv;
         r_cnv_p  <= r_cnv_s;
         r_scki_s <= scki;
         r_scki_p <= r_scki_s;
         r_sdi_s  <= sdi;
         r_scko   <= {N_DEV{r_scki_s}};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_mode_l     <= '0;
         r_conv_count <= '0;
         r_ent        <= '0;
         r_bit        <= '0;
      end else if (w_cnv_take) begin
         r_state <= S_CONV;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_CONV: begin
               if (r_cnt == CW'(CONV_CYCLES - 1)) begin
                  r_state      <= S_READ;
                  r_mode_l     <= mode;
                  r_conv_count <= r_conv_count + 16'd1;
                  r_ent        <= '0;
                  r_bit        <= BW'(EW - 1);
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_READ: begin
               // r_bit counts down so it indexes the entry word MSB first
               if (w_scki_take && (r_ent < r_act_len)) begin
                  if (r_bit == '0) begin
                     r_bit <= BW'(EW - 1);
                     r_ent <= r_ent + LW'(1);
                  end else begin
                     r_bit <= r_bit - BW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            r_act_chan[i]  <= 3'(i);
            r_act_span[i]  <= 3'd7;
            r_pend_chan[i] <= '0;
            r_pend_span[i] <= '0;
         end
         r_act_len  <= LW'(N_CH);
         r_pend_len <= '0;
         r_sdi_sr   <= '0;
         r_sdi_cnt  <= '0;
      end else if (w_cnv_take) begin
         if (r_pend_len != '0) begin
            r_act_chan <= r_pend_chan;
            r_act_span <= r_pend_span;
            r_act_len  <= r_pend_len;
         end
         r_pend_len <= '0;
         r_sdi_cnt  <= '0;
      end else if (w_scki_take) begin
         r_sdi_sr  <= {r_sdi_sr[5:0], r_sdi_s};
         r_sdi_cnt <= r_sdi_cnt + 3'd1;
         if (w_append) begin
            for (int i = 0; i < N_CH; i++) begin
               if (r_pend_len == LW'(i)) begin
                  r_pend_chan[i] <= r_sdi_sr[4:2];
                  r_pend_span[i] <= {r_sdi_sr[1:0], r_sdi_s};
               end
            end
            r_pend_len <= r_pend_len + LW'(1);
         end
      end
   end

   always_comb begin
      w_sel_chan = '0;
      w_sel_span = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (r_ent == LW'(i)) begin
            w_sel_chan = r_act_chan[i];
            w_sel_span = r_act_span[i];
         end
      end
   end

   assign w_in_frame = (r_state == S_READ) && (r_ent < r_act_len);

   always_comb begin
      for (int d = 0; d < N_DEV; d++) begin
         w_word[d] = {f_result(r_mode_l, r_conv_count, 32'(d), w_sel_chan),
                      w_sel_chan, w_sel_span};
         sdo[d]    = w_in_frame & w_word[d][r_bit];
      end
   end

   assign busy       = (r_state == S_CONV);
   assign scko       = r_scko;
   assign conv_count = r_conv_count;

endmodule

// File: tb/tb_ltc2333_emulator.sv
`timescale 1ns/1ps
// tb_ltc2333_emulator: directed and randomized readouts checked
// against a frame-level behavioural model.
module tb_ltc2333_emulator;

   localparam int N_DEV = 8;
   localparam int N_CH  = 8;
   localparam int EW    = 24;
   localparam int CONV  = 50;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [1:0]       mode = 2'd0;
   logic             cnv = 1'b0;
   logic             scki = 1'b0;
   logic             sdi = 1'b0;
   logic             busy;
   logic [N_DEV-1:0] scko;
   logic [N_DEV-1:0] sdo;
   logic [15:0]      conv_count;

   always #5 clk = ~clk;

   ltc2333_emulator #(
      .N_DEV(N_DEV), .N_CH(N_CH), .RES_BITS(18), .CONV_CYCLES(CONV)
   ) dut (
      .clk(clk), .reset(reset), .mode(mode), .cnv(cnv), .scki(scki),
      .sdi(sdi), .busy(busy), .scko(scko), .sdo(sdo),
      .conv_count(conv_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int   m_cc, m_mode, m_ptr, m_bits;
   logic [7:0] m_sr;
   int   m_ach[$], m_asp[$], m_pch[$], m_psp[$];
   logic tx[$];
   logic cap [N_DEV][256];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic exp_bit(int d, int p);
      int e, b, ch, sp;
      logic [17:0] r;
      logic [23:0] w;
      if (p >= m_ach.size() * EW) return 1'b0;
      e  = p / EW;
      b  = p % EW;
      ch = m_ach[e];
      sp = m_asp[e];
      case (m_mode)
         0: r = 18'(d * 16 + ch);
         1: r = 18'((m_cc + ch) % 262144);
         2: r = 18'd0;
         default: r = (m_cc % 2 == 0) ? 18'h2AAAA : 18'h15555;
      endcase
      w = {r, 3'(ch), 3'(sp)};
      return w[23 - b];
   endfunction

   function automatic logic [7:0] exp_sdo();
      logic [7:0] v;
      for (int d = 0; d < N_DEV; d++) v[d] = exp_bit(d, m_ptr);
      return v;
   endfunction

   function automatic logic [23:0] field(int d, int e);
      logic [23:0] w;
      for (int k = 0; k < EW; k++) w[23 - k] = cap[d][e * EW + k];
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_ach.delete(); m_asp.delete();
      m_pch.delete(); m_psp.delete();
      for (int i = 0; i < N_CH; i++) begin
         m_ach.push_back(i);
         m_asp.push_back(7);
      end
      m_cc = 0; m_mode = 0; m_ptr = 0; m_bits = 0; m_sr = '0;
   endtask

   task automatic model_cnv();
      if (m_pch.size() > 0) begin
         m_ach = m_pch;
         m_asp = m_psp;
      end
      m_pch.delete(); m_psp.delete();
      m_bits = 0;
   endtask

   task automatic model_scki(input logic b);
      m_ptr++;
      m_sr = {m_sr[6:0], b};
      m_bits++;
      if (m_bits == 8) begin
         m_bits = 0;
         if (m_sr[7] && m_pch.size() < N_CH) begin
            m_pch.push_back(int'(m_sr[5:3]));
            m_psp.push_back(int'(m_sr[2:0]));
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; cnv = 1'b0; scki = 1'b0; sdi = 1'b0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_sdo", sdo, 0);
      check("rst_scko", scko, 0);
      check("rst_count", conv_count, 0);
      reset = 1'b0;
      model_reset();
      tick();
   endtask

   task automatic conv(input int md, input int glitch, input bit with_scki);
      int cnt;
      mode = 2'(md);
      cnv  = 1'b1;
      scki = with_scki;
      tick(); tick();
      cnv  = 1'b0;
      scki = 1'b0;
      model_cnv();
      cnt = 0;
      while (busy === 1'b1 && cnt < 200) begin
         if (glitch >= 0 && cnt == glitch) cnv = 1'b1;
         if (glitch >= 0 && cnt == glitch + 2) cnv = 1'b0;
         cnt++;
         tick();
      end
      cnv = 1'b0;
      check("busy_len", cnt, CONV);
      m_cc   = (m_cc + 1) % 65536;
      m_mode = md;
      m_ptr  = 0;
      check("conv_count", conv_count, m_cc);
      for (int d = 0; d < N_DEV; d++)
         for (int k = 0; k < 256; k++) cap[d][k] = 1'bx;
   endtask

   task automatic rd(input int n);
      logic b;
      logic [7:0] s;
      for (int i = 0; i < n; i++) begin
         b = (tx.size() > 0) ? tx.pop_front() : 1'b0;
         s = sdo;
         if (m_ptr < 256)
            for (int d = 0; d < N_DEV; d++) cap[d][m_ptr] = s[d];
         check($sformatf("sdo[%0d]", m_ptr), s, exp_sdo());
         sdi  = b;
         scki = 1'b1;
         tick(); tick();
         check("scko_hi", scko, 8'hFF);
         scki = 1'b0;
         tick(); tick();
         check("scko_lo", scko, 8'h00);
         model_scki(b);
      end
   endtask

   task automatic push_word(input logic [7:0] w);
      for (int k = 7; k >= 0; k--) tx.push_back(w[k]);
   endtask

   initial begin
      logic [23:0] f;
      logic        v;
      logic [15:0] c0;
      model_reset();
      do_reset();

      conv(0, -1, 0);
      rd(196);
      f = field(2, 0);
      check("m0_d2_e0", f, 24'h000807);
      f = field(2, 7);
      check("m0_d2_e7", f, 24'h0009FF);
      v = 1'b0;
      for (int k = 192; k < 196; k++) v = v | cap[2][k];
      check("m0_tail", v, 0);

      do_reset();
      conv(1, -1, 0);
      rd(196);
      conv(1, -1, 0);
      rd(96);
      f = field(0, 3);
      check("m1_ch3", f[23:6], 5);

      push_word(8'h9D);
      push_word(8'h88);
      rd(16);
      conv(2, -1, 0);
      rd(60);
      f = field(0, 0);
      check("seq_e0", f[5:0], 6'b011101);
      f = field(0, 1);
      check("seq_e1", f[5:0], 6'b001000);
      v = 1'b0;
      for (int d = 0; d < N_DEV; d++)
         for (int k = 48; k < 60; k++) v = v | cap[d][k];
      check("seq_tail", v, 0);

      c0 = conv_count;
      conv(3, 10, 0);
      check("glitch_cnt", conv_count, c0 + 16'd1);
      rd(52);

      mode = 2'd0;
      cnv = 1'b1;
      tick(); tick();
      cnv = 1'b0;
      repeat (20) tick();
      check("midconv_busy", busy, 1);
      do_reset();
      conv(0, -1, 0);

      rd(30);
      do_reset();
      conv(0, -1, 0);
      rd(196);

      repeat (20) begin
         int nw;
         nw = $urandom_range(0, 10);
         for (int i = 0; i < nw; i++) push_word(8'($urandom % 256));
         conv(int'($urandom % 4), -1, ($urandom % 4) == 0);
         rd($urandom_range(0, 210));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: timeout got running expected finished");
      $fatal(1);
   end

endmodule
